// File: rtl/mem_arbiter.sv
// Two-port arbiter (VGA read / SD-loader write) for an asynchronous PSRAM, one access at a time.
// Optional write-starvation guard: define MEM_ARB_WR_GUARD_EN.
module mem_arbiter #(
  parameter int WAIT_CYCLES  = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk50,
  input  logic        reset,
  input  logic        rd_req,
  input  logic [22:0] rd_addr,
  output logic [15:0] rd_data,
  output logic        rd_ack,
  input  logic        wr_req,
  input  logic [22:0] wr_addr,
  input  logic [15:0] wr_data,
  input  logic [1:0]  wr_be,
  output logic        wr_ack,
  output logic        busy,
  output logic [22:0] MT_ADDR,
  inout  wire  [15:0] MT_DATA,
  output logic        MT_CE,
  output logic        MT_OE,
  output logic        MT_WE,
  output logic        MT_UB,
  output logic        MT_LB,
  output logic        MT_ADV,
  output logic        MT_CLK,
  output logic        MT_CRE
);

  if (WAIT_CYCLES < 2 || WAIT_CYCLES > 15 || STARVE_LIMIT < 1) begin : g_param_check
    $error("mem_arbiter: WAIT_CYCLES must be 2..15 and STARVE_LIMIT at least 1");
  end

  typedef enum logic [1:0] {IDLE, RD_ACC, WR_ACC, RECOVER} state_t;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [22:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic [1:0]  be_q, be_d;
  logic        is_wr_q, is_wr_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic        grant_rd, grant_wr, force_wr;
  logic        data_oe;

  assign grant_rd = (state_q == IDLE) && rd_req && !force_wr;
  assign grant_wr = (state_q == IDLE) && wr_req && !grant_rd;

`ifdef MEM_ARB_WR_GUARD_EN
  localparam int GW = $clog2(STARVE_LIMIT + 1);
  logic [GW-1:0] guard_q, guard_d;

  // Counts reads granted over a waiting writer; saturates so the force stays asserted.
  assign force_wr = wr_req && (guard_q >= GW'(STARVE_LIMIT));

  always_comb begin
    guard_d = guard_q;
    if (!wr_req || grant_wr) guard_d = '0;
    else if (grant_rd && (guard_q < GW'(STARVE_LIMIT))) guard_d = guard_q + 1'b1;
  end

  always_ff @(posedge clk50) begin
    if (!reset) guard_q <= '0;
    else        guard_q <= guard_d;
  end
`else
  assign force_wr = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk50) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      be_q      <= '0;
      is_wr_q   <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      be_q      <= be_d;
      is_wr_q   <= is_wr_d;
      rd_data_q <= rd_data_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    be_d      = be_q;
    is_wr_d   = is_wr_q;
    rd_data_d = rd_data_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (grant_rd) begin
          state_d = RD_ACC;
          addr_d  = rd_addr;
          is_wr_d = 1'b0;
        end else if (grant_wr) begin
          state_d = WR_ACC;
          addr_d  = wr_addr;
          data_d  = wr_data;
          be_d    = wr_be;
          is_wr_d = 1'b1;
        end
      end
      RD_ACC, WR_ACC: begin
        if (cnt_q == LAST_CNT) begin
          state_d = RECOVER;
          cnt_d   = '0;
          if (state_q == RD_ACC) rd_data_d = MT_DATA;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    MT_CE   = 1'b1;
    MT_OE   = 1'b1;
    MT_WE   = 1'b1;
    MT_UB   = 1'b1;
    MT_LB   = 1'b1;
    data_oe = 1'b0;
    rd_ack  = 1'b0;
    wr_ack  = 1'b0;
    busy    = (state_q != IDLE);
    unique case (state_q)
      RD_ACC: begin
        MT_CE = 1'b0;
        MT_OE = 1'b0;
        MT_UB = 1'b0;
        MT_LB = 1'b0;
      end
      WR_ACC: begin
        MT_CE   = 1'b0;
        MT_WE   = 1'b0;
        MT_UB   = ~be_q[1];
        MT_LB   = ~be_q[0];
        data_oe = 1'b1;
      end
      // Write data stays on the bus one extra cycle to cover PSRAM hold time.
      RECOVER: begin
        data_oe = is_wr_q;
        rd_ack  = !is_wr_q;
        wr_ack  = is_wr_q;
      end
      default: ;
    endcase
  end

  assign MT_DATA = data_oe ? data_q : 16'hzzzz;
  assign MT_ADDR = addr_q;
  assign rd_data = rd_data_q;
  assign MT_ADV  = 1'b0;
  assign MT_CLK  = 1'b0;
  assign MT_CRE  = 1'b0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small behavioural PSRAM on MT_DATA.
// Build with or without MEM_ARB_WR_GUARD_EN; the starvation expectations follow the macro.
module tb_mem_arbiter;

  localparam int WAIT_CYCLES  = 4;
  localparam int STARVE_LIMIT = 4;
  localparam int NV           = 7;

  logic        clk50 = 1'b0;
  logic        reset;
  logic        rd_req, wr_req;
  logic [22:0] rd_addr, wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  wr_be;
  logic [15:0] rd_data;
  logic        rd_ack, wr_ack, busy;
  logic [22:0] MT_ADDR;
  tri1  [15:0] mt_data;
  logic        MT_CE, MT_OE, MT_WE, MT_UB, MT_LB, MT_ADV, MT_CLK, MT_CRE;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk50 = ~clk50;

  mem_arbiter #(.WAIT_CYCLES(WAIT_CYCLES), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk50(clk50), .reset(reset),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_ack(rd_ack),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be), .wr_ack(wr_ack),
    .busy(busy), .MT_ADDR(MT_ADDR), .MT_DATA(mt_data),
    .MT_CE(MT_CE), .MT_OE(MT_OE), .MT_WE(MT_WE), .MT_UB(MT_UB), .MT_LB(MT_LB),
    .MT_ADV(MT_ADV), .MT_CLK(MT_CLK), .MT_CRE(MT_CRE)
  );

  // PSRAM read model: 0xBEEF at word 0x123, otherwise low address bits XOR 0x5A5A.
  logic        model_oe;
  logic [15:0] model_rd;
  assign model_oe = !MT_CE && !MT_OE && MT_WE;
  assign model_rd = (MT_ADDR == 23'h000123) ? 16'hBEEF : (MT_ADDR[15:0] ^ 16'h5A5A);
  assign mt_data  = model_oe ? model_rd : 16'hzzzz;

  typedef struct {
    logic        is_wr;
    logic [22:0] addr;
    logic [15:0] data;
    logic [1:0]  be;
    logic [15:0] exp_rd;
    logic [1:0]  exp_ublb;
  } vec_t;

  typedef struct {
    int          ack_cyc;
    int          strobe_cyc;
    int          bad;
    int          other_ack;
    int          idle_bad;
    logic        rec_ok;
    logic [1:0]  ublb;
    logic [15:0] rd_val;
    logic [15:0] rd_hold;
  } res_t;

  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Issue one request at a clock edge, watch the bus each cycle, drop req on the ack-sampling edge.
  task automatic run_access(input vec_t v, output res_t r);
    r = '{ack_cyc: -1, strobe_cyc: 0, bad: 0, other_ack: 0, idle_bad: 0,
          rec_ok: 1'b0, ublb: 2'b00, rd_val: 16'h0, rd_hold: 16'h0};
    @(posedge clk50); #1;
    if (v.is_wr) begin
      wr_req = 1'b1; wr_addr = v.addr; wr_data = v.data; wr_be = v.be;
    end else begin
      rd_req = 1'b1; rd_addr = v.addr;
    end
    for (int j = 0; j < 3 * WAIT_CYCLES + 6 && r.ack_cyc < 0; j++) begin
      @(negedge clk50);
      if (j == 1) begin
        rd_addr = ~v.addr; wr_addr = ~v.addr; wr_data = ~v.data; wr_be = ~v.be;
      end
      if (MT_CE === 1'b0) begin
        r.strobe_cyc++;
        r.ublb = {MT_UB, MT_LB};
        if (MT_ADDR !== v.addr) r.bad++;
        if (v.is_wr) begin
          if (MT_WE !== 1'b0 || MT_OE !== 1'b1 || mt_data !== v.data) r.bad++;
        end else if (MT_OE !== 1'b0 || MT_WE !== 1'b1) r.bad++;
      end
      if (rd_ack === 1'b1 || wr_ack === 1'b1) begin
        r.ack_cyc   = j;
        r.other_ack = v.is_wr ? int'(rd_ack) : int'(wr_ack);
        r.rd_val    = rd_data;
        r.rec_ok    = ({MT_CE, MT_OE, MT_WE, MT_UB, MT_LB} === 5'b11111) && (MT_ADDR === v.addr)
                      && (mt_data === (v.is_wr ? v.data : 16'hFFFF)) && (busy === 1'b1);
      end
    end
    @(posedge clk50); #1;
    rd_req = 1'b0; wr_req = 1'b0;
    repeat (2) begin
      @(negedge clk50);
      if (busy !== 1'b0 || rd_ack !== 1'b0 || wr_ack !== 1'b0) r.idle_bad++;
    end
    r.rd_hold = rd_data;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t r;
    int rd_start, wr_start, rd_ack_c, wr_ack_c, both, reads_before, w_first, ack_seen;
    logic drop_rd, drop_wr;

    vecs[0] = '{1'b0, 23'h000123, 16'h0000, 2'b00, 16'hBEEF, 2'b00};
    vecs[1] = '{1'b1, 23'h7FFFFF, 16'hA55A, 2'b10, 16'h0000, 2'b01};
    vecs[2] = '{1'b1, 23'h000010, 16'h1234, 2'b00, 16'h0000, 2'b11};
    vecs[3] = '{1'b1, 23'h400000, 16'hFFFF, 2'b01, 16'h0000, 2'b10};
    vecs[4] = '{1'b0, 23'h7FFFFF, 16'h0000, 2'b00, 16'hA5A5, 2'b00};
    vecs[5] = '{1'b1, 23'h2AAAAA, 16'h0F0F, 2'b11, 16'h0000, 2'b00};
    vecs[6] = '{1'b0, 23'h000000, 16'h0000, 2'b00, 16'h5A5A, 2'b00};

    reset = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
    rd_addr = '0; wr_addr = '0; wr_data = '0; wr_be = '0;
    repeat (2) @(posedge clk50);
    @(negedge clk50);
    check("reset.busy_acks", {busy, rd_ack, wr_ack}, 3'b000);
    check("reset.rd_data", rd_data, 16'h0000);
    check("reset.mt_addr", MT_ADDR, 23'h0);
    check("reset.strobes", {MT_CE, MT_OE, MT_WE, MT_UB, MT_LB}, 5'b11111);
    check("reset.mt_data_z", mt_data, 16'hFFFF);
    check("reset.adv_clk_cre", {MT_ADV, MT_CLK, MT_CRE}, 3'b000);
    @(posedge clk50); #1;
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      run_access(vecs[i], r);
      check($sformatf("v%0d.ack_latency", i), r.ack_cyc, WAIT_CYCLES + 1);
      check($sformatf("v%0d.strobe_cycles", i), r.strobe_cyc, WAIT_CYCLES);
      check($sformatf("v%0d.bus_during_access", i), r.bad, 0);
      check($sformatf("v%0d.ub_lb", i), r.ublb, vecs[i].exp_ublb);
      check($sformatf("v%0d.recover_bus", i), r.rec_ok, 1'b1);
      check($sformatf("v%0d.wrong_ack", i), r.other_ack, 0);
      check($sformatf("v%0d.no_duplicate", i), r.idle_bad, 0);
      if (!vecs[i].is_wr) begin
        check($sformatf("v%0d.rd_data", i), r.rd_val, vecs[i].exp_rd);
        check($sformatf("v%0d.rd_data_hold", i), r.rd_hold, vecs[i].exp_rd);
      end
    end

    // Simultaneous requests: read first, write right after the read's RECOVER.
    rd_start = -1; wr_start = -1; rd_ack_c = -1; wr_ack_c = -1; both = 0;
    @(posedge clk50); #1;
    rd_req = 1'b1; rd_addr = 23'h000055;
    wr_req = 1'b1; wr_addr = 23'h000066; wr_data = 16'hC3C3; wr_be = 2'b11;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk50);
      drop_rd = (rd_ack === 1'b1);
      drop_wr = (wr_ack === 1'b1);
      if (drop_rd && rd_ack_c < 0) begin rd_ack_c = j; check("simul.rd_data", rd_data, 16'h5A0F); end
      if (drop_wr && wr_ack_c < 0) wr_ack_c = j;
      if (drop_rd && drop_wr) both++;
      if (!MT_CE && !MT_OE && rd_start < 0) rd_start = j;
      if (!MT_CE && !MT_WE && wr_start < 0) wr_start = j;
      @(posedge clk50); #1;
      if (drop_rd) rd_req = 1'b0;
      if (drop_wr) wr_req = 1'b0;
    end
    rd_req = 1'b0; wr_req = 1'b0;
    check("simul.rd_start", rd_start, 1);
    check("simul.rd_ack", rd_ack_c, WAIT_CYCLES + 1);
    check("simul.spacing", wr_start - rd_start, WAIT_CYCLES + 2);
    check("simul.wr_ack", wr_ack_c, 2 * WAIT_CYCLES + 3);
    check("simul.both_acks", both, 0);

    // Reads held continuously with a pending write: the guard decides when the write gets in.
    reads_before = 0; w_first = -1;
    @(posedge clk50); #1;
    rd_req = 1'b1; rd_addr = 23'h000010;
    wr_req = 1'b1; wr_addr = 23'h000020; wr_data = 16'h7777; wr_be = 2'b11;
    for (int j = 0; j < 50; j++) begin
      @(negedge clk50);
      drop_wr = (wr_ack === 1'b1);
      drop_rd = (rd_ack === 1'b1) && (j >= 30);
      if (rd_ack === 1'b1 && w_first < 0) reads_before++;
      if (drop_wr && w_first < 0) w_first = j;
      @(posedge clk50); #1;
      if (drop_rd) rd_req = 1'b0;
      if (drop_wr) wr_req = 1'b0;
    end
    rd_req = 1'b0; wr_req = 1'b0;
`ifdef MEM_ARB_WR_GUARD_EN
    check("starve.reads_before_write", reads_before, STARVE_LIMIT);
    check("starve.write_ack_cycle", w_first, 29);
`else
    check("starve.reads_before_write", reads_before, 6);
    check("starve.write_ack_cycle", w_first, 41);
`endif
    repeat (8) @(posedge clk50);

    // Reset in the 3rd WR_ACC cycle: bus released next cycle, no wr_ack, then a clean read.
    ack_seen = 0;
    @(posedge clk50); #1;
    wr_req = 1'b1; wr_addr = 23'h123456; wr_data = 16'h3C3C; wr_be = 2'b11;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk50);
      if (wr_ack === 1'b1) ack_seen++;
    end
    check("rst.mid_write", {MT_CE, MT_WE, mt_data}, {2'b00, 16'h3C3C});
    reset = 1'b0;
    @(negedge clk50);
    check("rst.strobes", {MT_CE, MT_OE, MT_WE, MT_UB, MT_LB}, 5'b11111);
    check("rst.mt_data_z", mt_data, 16'hFFFF);
    check("rst.busy_acks", {busy, rd_ack, wr_ack}, 3'b000);
    check("rst.addr_rd_data", {MT_ADDR, rd_data}, 39'h0);
    reset = 1'b1; wr_req = 1'b0;
    repeat (8) begin
      @(negedge clk50);
      if (wr_ack === 1'b1 || busy === 1'b1) ack_seen++;
    end
    check("rst.no_ack", ack_seen, 0);
    run_access(vecs[0], r);
    check("rst.read_latency", r.ack_cyc, WAIT_CYCLES + 1);
    check("rst.read_data", r.rd_val, 16'hBEEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
